apb_mem_slave: RTL



---
 rtl/apb_mem_slave.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//
// APB completer that exposes a DEPTH x DATA_W word memory, with a fixed
// number of wait states (WAIT) inserted in every access phase.
//
// Parameters
//   ADDR_W  paddr width in bits
//   DATA_W  pwdata / prdata width in bits
//   DEPTH   number of memory words, 1 .. 2**ADDR_W
//   WAIT    wait states per transfer, 0 .. 15
//
// Ports
//   pclk      in   sole clock, all state changes on its rising edge
//   preset_n  in   asynchronous active-low reset
//   psel      in   completer select
//   penable   in   access-phase indicator
//   pwrite    in   1 = write, 0 = read
//   paddr     in   word address
//   pwdata    in   write data
//   prdata    out  read data, valid while pready=1 on a read
//   pready    out  transfer complete (combinational)
//   pslverr   out  error response, address outside 0 .. DEPTH-1
//
// Address, direction and write data are captured on the setup edge and
// used for the whole access phase, so requester-side changes during the
// access phase are ignored. Read data is fetched on the setup edge as well,
// which gives the memory a full cycle of registered-read latency.
// Memory contents are not reset.
// -----------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 0
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    // Memory index width; a one-word memory still needs a one-bit index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LP_WAIT  = 4'(WAIT);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Control state
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [IDX_W-1:0]  r_addr_idx;   // captured address, in-range part
    logic              r_addr_err;   // captured address >= DEPTH
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic              r_rd_sel;     // 1: prdata shows fetched word, 0: zero

    // Memory and its registered read port
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_mem_q;

    logic              w_setup;
    logic              w_in_range;
    logic              w_ready;
    logic              w_mem_we;
    logic              w_rd_fetch;
    logic [IDX_W-1:0]  w_rd_idx;

    assign w_setup    = psel & ~penable;
    assign w_in_range = ({1'b0, paddr} < LP_DEPTH);
    assign w_rd_idx   = paddr[IDX_W-1:0];

    // Only a read setup edge to a valid address touches the read port.
    assign w_rd_fetch = w_setup & ~pwrite & w_in_range;

    // State is cleared asynchronously by reset, so a reset in the middle of
    // an access phase drops pready at once and blocks the memory write.
    assign w_ready  = (r_state == S_ACCESS) && (r_cnt == 4'd0) && psel && penable;
    assign w_mem_we = w_ready & r_write & ~r_addr_err;

    assign pready  = w_ready;
    assign pslverr = w_ready & r_addr_err;
    assign prdata  = r_rd_sel ? r_mem_q : '0;

    // -------------------------------------------------------------------------
    // Transfer FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr_idx <= '0;
            r_addr_err <= 1'b0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            if (w_setup) begin
                // A setup edge always starts a new transfer, abandoning any
                // unfinished one without writing it.
                r_state    <= S_ACCESS;
                r_cnt      <= LP_WAIT;
                r_addr_idx <= paddr[IDX_W-1:0];
                r_addr_err <= ~w_in_range;
                r_wdata    <= pwdata;
                r_write    <= pwrite;
                // Writes leave the previously returned read data untouched.
                if (!pwrite) begin
                    r_rd_sel <= w_in_range;
                end
            end else if (r_state == S_ACCESS) begin
                if (!psel) begin
                    // Requester deselected before completion: abort.
                    r_state <= S_IDLE;
                end else if (penable) begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;        // completing edge
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory: single write port from the captured transfer, registered read
    // port loaded on the read setup edge. No reset, contents survive preset_n.
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (w_mem_we) begin
            r_mem[r_addr_idx] <= r_wdata;
        end
        if (w_rd_fetch) begin
            r_mem_q <= r_mem[w_rd_idx];
        end
    end

endmodule
